// File: rtl/alu_sequencer_pkg.sv
// Shared types for the alu sequencer: opcode and FSM state encodings plus small op helpers.
package alu_sequencer_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_BEG  = 3'd1,
    S_LDA  = 3'd2,
    S_LDB  = 3'd3,
    S_WAIT = 3'd4,
    S_CAP1 = 3'd5,
    S_RSP  = 3'd6
  } state_e;

  // mul and div return a second result byte on the cycle after END.
  function automatic logic is_two_byte(op_e op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/alu_sequencer_wdog.sv
// S_WAIT watchdog: counts while enabled, clears when disabled, flags the terminal count.
// Only compiled with ALU_SEQ_TIMEOUT_EN defined, the only build that instantiates it.
`ifdef ALU_SEQ_TIMEOUT_EN
module alu_seq_wdog #(
  parameter int LIMIT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  output logic tc_o
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt_q;

  assign tc_o = en_i && (cnt_q == CW'(LIMIT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (!en_i) begin
      cnt_q <= '0;
    end else if (!tc_o) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule
`endif

// File: rtl/alu_sequencer.sv
// Valid/ready front-end that loads one {op,A,B} job into the serial-bus alu and returns its result.
// Optional S_WAIT timeout is enabled by defining ALU_SEQ_TIMEOUT_EN.
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int W           = 8,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic [1:0]     req_op,
  input  logic [W-1:0]   req_a,
  input  logic [W-1:0]   req_b,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [2*W-1:0] rsp_data,
  output logic           rsp_err,
  output logic           busy,
  output logic           alu_begin,
  output logic [1:0]     alu_op_code,
  output logic [W-1:0]   alu_inbus,
  input  logic           alu_end,
  input  logic [W-1:0]   alu_outbus
);

  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("alu_sequencer: TIMEOUT_CYC must be at least 1");
  end

  state_e           state_q;
  op_e              op_q;
  logic [W-1:0]     a_q;
  logic [W-1:0]     b_q;
  logic [W-1:0]     byte0_q;
  logic             req_ready_q;
  logic             rsp_valid_q;
  logic [2*W-1:0]   rsp_data_q;
  logic             rsp_err_q;
  logic             busy_q;
  logic             alu_begin_q;
  logic [1:0]       alu_op_code_q;
  logic [W-1:0]     alu_inbus_q;
  logic             wdog_tc;

`ifdef ALU_SEQ_TIMEOUT_EN
  alu_seq_wdog #(
    .LIMIT (TIMEOUT_CYC)
  ) u_wdog (
    .clk   (clk),
    .reset (reset),
    .en_i  (state_q == S_WAIT),
    .tc_o  (wdog_tc)
  );
`else
  assign wdog_tc = 1'b0;
`endif

  // Every output is a flop so the alu never sees a combinational path from client inputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      op_q          <= OP_ADD;
      a_q           <= '0;
      b_q           <= '0;
      byte0_q       <= '0;
      req_ready_q   <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
      rsp_err_q     <= 1'b0;
      busy_q        <= 1'b0;
      alu_begin_q   <= 1'b0;
      alu_op_code_q <= 2'b00;
      alu_inbus_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values of the others.
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            op_q          <= op_e'(req_op);
            a_q           <= req_a;
            b_q           <= req_b;
            rsp_err_q     <= 1'b0;
            req_ready_q   <= 1'b0;
            busy_q        <= 1'b1;
            alu_begin_q   <= 1'b1;
            alu_op_code_q <= req_op;
            alu_inbus_q   <= '0;
            state_q       <= S_BEG;
          end
        end
        S_BEG: begin
          alu_inbus_q <= a_q;
          state_q     <= S_LDA;
        end
        S_LDA: begin
          alu_begin_q <= 1'b0;
          alu_inbus_q <= b_q;
          state_q     <= S_LDB;
        end
        S_LDB: begin
          alu_inbus_q <= '0;
          state_q     <= S_WAIT;
        end
        S_WAIT: begin
          if (alu_end) begin
            byte0_q <= alu_outbus;
            if (is_two_byte(op_q)) begin
              state_q <= S_CAP1;
            end else begin
              rsp_data_q  <= {{W{1'b0}}, alu_outbus};
              rsp_valid_q <= 1'b1;
              state_q     <= S_RSP;
            end
          end else if (wdog_tc) begin
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= 1'b1;
            state_q     <= S_RSP;
          end
        end
        S_CAP1: begin
          // byte0 is hi for mul and remainder for div, so it always lands in the upper half.
          rsp_data_q  <= {byte0_q, alu_outbus};
          rsp_valid_q <= 1'b1;
          state_q     <= S_RSP;
        end
        S_RSP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          rsp_valid_q <= 1'b0;
          req_ready_q <= 1'b1;
          busy_q      <= 1'b0;
          alu_begin_q <= 1'b0;
          alu_inbus_q <= '0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready   = req_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_err     = rsp_err_q;
  assign busy        = busy_q;
  assign alu_begin   = alu_begin_q;
  assign alu_op_code = alu_op_code_q;
  assign alu_inbus   = alu_inbus_q;

endmodule
